// File: rtl/kamikaze_imem_arbiter.sv
// -----------------------------------------------------------------------------
// kamikaze_imem_arbiter
//
// Arbitrates a single-port instruction/data memory between the fetch unit (if)
// and the load/store unit (ls). At most one request is granted per cycle. The
// memory returns read data exactly one cycle after an accepted read. A small
// FSM remembers whose read is in flight so that the returned word is routed to
// the right requester.
//
// Optional feature (macro KAMIKAZE_ARB_RR_EN):
//   undefined : fixed priority, ls over if; no last-winner register exists.
//   defined   : round-robin between the two requesters when both request,
//               using a 1-bit last-winner register updated on every grant.
//
// Ports:
//   clk_i                     clock, rising edge
//   rst_i                     asynchronous active-low reset
//   if_req_i, if_addr_i       fetch request / byte address
//   if_gnt_o                  fetch accepted this cycle (combinational)
//   if_rvalid_o, if_rdata_o   fetch response valid / data
//   if_flush_i                discard an outstanding fetch response
//   ls_req_i, ls_we_i         load/store request / write enable
//   ls_addr_i, ls_wdata_i     load/store byte address / write data
//   ls_be_i                   load/store byte enables
//   ls_gnt_o                  load/store accepted this cycle (combinational)
//   ls_rvalid_o, ls_rdata_o   load response valid / data
//   mem_req_o, mem_we_o       memory request / write enable
//   mem_be_o                  memory byte enables
//   mem_addr_o, mem_wdata_o   memory word-aligned address / write data
//   mem_rdata_i               memory read data, one cycle after a read grant
// -----------------------------------------------------------------------------
module kamikaze_imem_arbiter (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        if_flush_i,
   input  logic        ls_req_i,
   input  logic        ls_we_i,
   input  logic [31:0] ls_addr_i,
   input  logic [31:0] ls_wdata_i,
   input  logic [3:0]  ls_be_i,
   output logic        ls_gnt_o,
   output logic        ls_rvalid_o,
   output logic [31:0] ls_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESP_IF = 2'd1,
      RESP_LS = 2'd2
   } state_t;

   state_t state, state_next;
   logic   ls_win;
   logic   if_win;

   // Byte-offset bits are dropped by word alignment.
   logic   unused_addr_bits;
   assign unused_addr_bits = ^{if_addr_i[1:0], ls_addr_i[1:0]};

`ifdef KAMIKAZE_ARB_RR_EN
   // 1 = ls won the most recent grant. Resets to "ls last" so the first
   // conflict after reset goes to the fetch unit.
   logic last_ls;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         last_ls <= 1'b1;
      end else if (ls_win || if_win) begin
         last_ls <= ls_win;
      end
   end

   // On a conflict the requester that did not win last time goes first.
   always_comb begin
      if (ls_req_i && if_req_i) begin
         ls_win = rst_i & ~last_ls;
      end else begin
         ls_win = rst_i & ls_req_i;
      end
   end
`else
   assign ls_win = rst_i & ls_req_i;
`endif

   // Grants are forced low while reset is asserted so every output reads 0.
   assign if_win = rst_i & if_req_i & ~ls_win;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = IDLE;
      if_gnt_o    = if_win;
      ls_gnt_o    = ls_win;
      mem_req_o   = if_win | ls_win;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      if_rvalid_o = 1'b0;
      if_rdata_o  = 32'h0;
      ls_rvalid_o = 1'b0;
      ls_rdata_o  = 32'h0;

      // A new grant always decides the next state, so a response can be
      // returned and a new request accepted in the same cycle.
      if (if_win) begin
         state_next = RESP_IF;
      end else if (ls_win && !ls_we_i) begin
         state_next = RESP_LS;
      end

      if (rst_i) begin
         if (ls_win) begin
            mem_we_o    = ls_we_i;
            mem_be_o    = ls_be_i;
            mem_addr_o  = {ls_addr_i[31:2], 2'b00};
            mem_wdata_o = ls_wdata_i;
         end else begin
            mem_be_o    = 4'hF;
            mem_addr_o  = {if_addr_i[31:2], 2'b00};
         end

         // A flush only kills the response currently being returned; a
         // fetch granted in the flush cycle is unaffected.
         if (state == RESP_IF && !if_flush_i) begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
         end
         if (state == RESP_LS) begin
            ls_rvalid_o = 1'b1;
            ls_rdata_o  = mem_rdata_i;
         end
      end
   end

endmodule

// File: doc/kamikaze_imem_arbiter.md
KAMIKAZE_IMEM_ARBITER -- requirements
Module: kamikaze_imem_arbiter

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_i  input  1  reset; asynchronous and active-low.
REQ-003 SHALL have if_req_i  input  1  fetch requests a read this cycle.
REQ-004 SHALL have if_addr_i  input  32  fetch byte address.
REQ-005 SHALL have if_gnt_o  output  1  fetch request accepted this cycle (combinational).
REQ-006 SHALL have if_rvalid_o / if_rdata_o  output  1 / 32  fetch read data valid / word.
REQ-007 SHALL have ls_req_i, ls_we_i  input  1 each  load/store request, write enable.
REQ-008 SHALL have ls_addr_i, ls_wdata_i  input  32 each; ls_be_i  input  4  byte enables.
REQ-009 SHALL have ls_gnt_o  output  1; ls_rvalid_o / ls_rdata_o  output  1 / 32.
REQ-010 SHALL have if_flush_i  input  1  discard any outstanding fetch response.
REQ-011 SHALL have mem_req_o, mem_we_o  output  1 each; mem_be_o  output  4; mem_addr_o, mem_wdata_o  output  32 each.
REQ-012 SHALL have mem_rdata_i  input  32  memory read word, valid exactly 1 cycle after an accepted read.

Function
REQ-013 SHALL grant at most one requester per cycle; mem_req_o = if_gnt_o | ls_gnt_o.
REQ-014 SHALL drive mem_addr_o = {winner_addr[31:2], 2'b00} (word-aligned).
REQ-015 SHALL drive mem_we_o, mem_be_o and mem_wdata_o from ls_* when ls wins, else mem_we_o=0 and mem_be_o=4'hF.
REQ-016 SHALL resolve conflicts with fixed priority, ls over if, unless KAMIKAZE_ARB_RR_EN is defined (REQ-026).
REQ-017 SHALL track the outstanding response in a state machine with states IDLE, RESP_IF and RESP_LS.
REQ-018 SHALL go to RESP_IF on an if grant, to RESP_LS on an ls read grant, and to IDLE on an ls write grant or no grant; transitions are evaluated every cycle.
REQ-019 SHALL allow back-to-back grants: a new grant may occur in the same cycle a response is returned.
REQ-020 SHALL in RESP_IF assert if_rvalid_o=1 with if_rdata_o=mem_rdata_i for one cycle; in RESP_LS assert ls_rvalid_o and ls_rdata_o in the same way.
REQ-021 SHALL produce no rvalid for writes.
REQ-022 SHALL, when if_flush_i=1 in state RESP_IF, suppress if_rvalid_o in that cycle; a fetch granted in the same cycle as the flush is kept and its response is delivered.
REQ-023 SHALL hold if_rdata_o and ls_rdata_o at 0 whenever the matching rvalid is 0.

Reset
REQ-024 SHALL on rst_i=0 immediately force state IDLE, the round-robin pointer to "ls last", and drive all outputs to 0 while reset is held.
REQ-025 SHALL drop a response in flight at reset; no rvalid appears on the first cycle after reset is released.

Configuration
REQ-026 With KAMIKAZE_ARB_RR_EN defined, the block SHALL alternate winners when both requesters request, using a 1-bit last-winner register updated on every grant; a lone requester always wins.
REQ-027 Without KAMIKAZE_ARB_RR_EN the block SHALL use fixed ls-over-if priority and SHALL contain no last-winner register.

Verification
REQ-028 Lone fetch: if_req_i=1, if_addr_i=0x6 -> if_gnt_o=1, mem_addr_o=0x4; next cycle with mem_rdata_i=0xDEADBEEF -> if_rvalid_o=1, if_rdata_o=0xDEADBEEF.
REQ-029 Conflict, fixed priority: both request for 3 cycles -> ls_gnt_o=1 in all 3 cycles and if_gnt_o=0; with RR_EN -> grants go if, ls, if.
REQ-030 Store: ls_we_i=1, ls_be_i=4'b0011, addr 0x10, wdata 0x1234 -> mem_we_o=1, mem_be_o=0x3, mem_addr_o=0x10; no ls_rvalid_o on the following cycle.
REQ-031 Flush: fetch granted at cycle N, if_flush_i=1 at N+1 -> if_rvalid_o=0 at N+1; a fetch granted at N+1 returns data at N+2.
REQ-032 Reset mid-read: ls read granted, rst_i=0 before the next edge -> all outputs 0; after release, no ls_rvalid_o until a new grant.
